// File: rtl/mem_byte_arbiter.sv
// mem_byte_arbiter
//   Shares one byte-wide, asynchronous-read memory between the instruction
//   fetch port and the data load port. A granted access is sequenced one
//   byte per cycle. The bytes are assembled little-endian into a word, and
//   the result is returned with a one-cycle done pulse to the owner.
//
//   Optional alignment check: define MEM_ARB_ALIGN_CHECK_EN to reject
//   unaligned word/half accesses at grant. A rejected access returns
//   done with rdata=0 and err=1. Without the macro err is tied to 0 and
//   unaligned accesses proceed byte by byte.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   if_req     in   fetch request, held until if_done
//   if_addr    in   fetch byte address (always a word access)
//   if_rdata   out  fetched word, valid while if_done=1
//   if_done    out  one-cycle fetch completion pulse
//   d_req      in   data request, held until d_done
//   d_addr     in   data byte address
//   d_size     in   00=byte, 01=half, 10/11=word
//   d_rdata    out  zero-extended load data, valid while d_done=1
//   d_done     out  one-cycle data completion pulse
//   err        out  misalignment flag, valid with either done pulse
//   mem_addr   out  byte address to memory (holds its value while idle)
//   mem_rdata  in   combinational read data for mem_addr
module mem_byte_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int WORD_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic [WORD_WIDTH-1:0]    if_rdata,
    output logic                     if_done,
    input  logic                     d_req,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [1:0]               d_size,
    output logic [WORD_WIDTH-1:0]    d_rdata,
    output logic                     d_done,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int LANES = WORD_WIDTH / DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [1:0]               r_beat;
    logic [1:0]               r_last;      // index of the final beat (N-1)
    logic                     r_owner_d;   // 1: data port owns the transfer
    logic                     r_prio_d;    // 1: data wins the next tie
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [WORD_WIDTH-1:0]    r_acc;
    logic                     r_if_done;
    logic                     r_d_done;

    logic                     w_if_pend;
    logic                     w_d_pend;
    logic                     w_grant_f;
    logic                     w_grant_d;
    logic [ADDRESS_WIDTH-1:0] w_grant_addr;
    logic [1:0]               w_grant_last;
    logic                     w_reject;
    logic                     w_xfer_end;

    always_comb begin
        // A requester still holds req during its own done cycle. It must not
        // be re-granted for that stale request.
        w_if_pend    = if_req && !r_if_done;
        w_d_pend     = d_req  && !r_d_done;
        w_grant_f    = 1'b0;
        w_grant_d    = 1'b0;
        w_grant_addr = if_addr;
        w_grant_last = 2'd3;
        w_reject     = 1'b0;
        w_xfer_end   = 1'b0;
        w_state_nxt  = r_state;

        case (r_state)
            S_IDLE: begin
                if (w_if_pend && (!w_d_pend || !r_prio_d)) begin
                    w_grant_f = 1'b1;
                end else if (w_d_pend) begin
                    w_grant_d    = 1'b1;
                    w_grant_addr = d_addr;
                    case (d_size)
                        2'b00:   w_grant_last = 2'd0;
                        2'b01:   w_grant_last = 2'd1;
                        default: w_grant_last = 2'd3;
                    endcase
                end
`ifdef MEM_ARB_ALIGN_CHECK_EN
                if (w_grant_f || w_grant_d) begin
                    w_reject = ((w_grant_last == 2'd3) && (w_grant_addr[1:0] != 2'b00)) ||
                               ((w_grant_last == 2'd1) && w_grant_addr[0]);
                end
`endif
                if (w_grant_f || w_grant_d) begin
                    // A rejected access skips XFER; its done comes straight from IDLE.
                    w_state_nxt = w_reject ? S_IDLE : S_XFER;
                end
            end
            S_XFER: begin
                if (r_beat == r_last) begin
                    w_xfer_end  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_beat     <= 2'd0;
            r_last     <= 2'd0;
            r_owner_d  <= 1'b0;
            r_prio_d   <= 1'b0;
            r_mem_addr <= '0;
            r_acc      <= '0;
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;

            // --- grant: latch the request and clear the result ---
            if (w_grant_f || w_grant_d) begin
                r_owner_d <= w_grant_d;
                r_prio_d  <= w_grant_f;
                r_beat    <= 2'd0;
                r_last    <= w_grant_last;
                // Clearing here leaves every lane >= N at zero.
                r_acc     <= '0;
                if (w_reject) begin
                    r_if_done <= w_grant_f;
                    r_d_done  <= w_grant_d;
                end else begin
                    r_mem_addr <= w_grant_addr;
                end
            end

            // --- beat: capture one byte lane, advance the address ---
            if (r_state == S_XFER) begin
                for (int k = 0; k < LANES; k++) begin
                    if (int'(r_beat) == k) begin
                        r_acc[k*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                    end
                end
                if (w_xfer_end) begin
                    r_if_done <= !r_owner_d;
                    r_d_done  <= r_owner_d;
                end else begin
                    r_beat     <= r_beat + 2'd1;
                    // Wraps naturally from all-ones to zero.
                    r_mem_addr <= r_mem_addr + ADDR_ONE;
                end
            end
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic r_err;

    // A reject is only ever flagged at grant, so err coincides with its done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign if_rdata = r_acc;
    assign d_rdata  = r_acc;
    assign if_done  = r_if_done;
    assign d_done   = r_d_done;
    assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Self-checking bench for mem_byte_arbiter. A transaction-level model predicts
// grant order (round-robin on ties), done timing (N+1 cycles from the sampled
// request), the address sequence and the assembled little-endian data.
// Directed cases are followed by a long randomized phase.
`timescale 1ns/1ps
module tb_mem_byte_arbiter;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [WW-1:0] if_rdata;
    logic          if_done;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [1:0]    d_size = 2'b00;
    logic [WW-1:0] d_rdata;
    logic          d_done;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];

    always #5 clk = ~clk;

    mem_byte_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WORD_WIDTH(WW)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_size   (d_size),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle-time %0t)", tag, act, exp, $time);
        end
    endtask

    // Requester / model state, index 0 = fetch, 1 = data
    int          cyc = 0;
    bit          rand_en = 1'b0;
    bit          act[2];
    bit          gnt[2];
    bit          in_done[2];
    int          done_cyc[2];
    int          start_cyc[2];
    int          lat[2];
    logic [31:0] exp_data[2];
    bit          exp_err[2];
    logic [31:0] ra[2];
    logic [1:0]  rs[2];
    int          nxt_cnt[2];
    logic [31:0] nxt_addr[2];
    logic [1:0]  nxt_size[2];
    logic [31:0] last_rdata[2];
    logic        last_err[2];
    int          next_grant = 0;
    bit          prefer_d = 1'b0;
    logic [31:0] xfer_base = '0;
    int          xfer_t = 0;
    int          xfer_n = 0;
    logic [31:0] maddr_exp = '0;
    int          done_log[$];

    function automatic int beats_of(input int r, input logic [1:0] sz);
        if (r == 0) return 4;
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] assemble(input logic [31:0] a, input int n);
        logic [31:0] w;
        logic [31:0] p;
        w = '0;
        for (int i = 0; i < n; i++) begin
            p = a + 32'(i);
            w[8*i +: 8] = mem[p[7:0]];
        end
        return w;
    endfunction

`ifdef MEM_ARB_ALIGN_CHECK_EN
    function automatic bit misaligned(input logic [31:0] a, input int n);
        return ((n == 4) && (a[1:0] != 2'b00)) || ((n == 2) && a[0]);
    endfunction
`endif

    task automatic drive();
        if_req  = act[0];
        if_addr = ra[0];
        d_req   = act[1];
        d_addr  = ra[1];
        d_size  = rs[1];
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            act[r] = 1'b0; gnt[r] = 1'b0; in_done[r] = 1'b0; nxt_cnt[r] = 0;
            ra[r] = '0; rs[r] = 2'b00;
        end
        next_grant = 0;
        prefer_d   = 1'b0;
        xfer_n     = 0;
        maddr_exp  = '0;
        drive();
    endtask

    task automatic issue(input int r, input logic [31:0] a, input logic [1:0] sz, input int cnt);
        nxt_addr[r] = a;
        nxt_size[r] = sz;
        nxt_cnt[r]  = cnt;
    endtask

    // One clock cycle: check this cycle's outputs, update requesters, then
    // predict what the arbiter decides at the edge that ends this cycle.
    task automatic step();
        bit          e;
        bit          bad;
        bit          pend[2];
        logic        dn;
        logic [31:0] rd;
        int          pick;
        int          n;
        @(posedge clk);
        #1;
        cyc++;
        if (xfer_n > 0 && cyc > xfer_t && cyc <= xfer_t + xfer_n)
            maddr_exp = xfer_base + 32'(cyc - xfer_t - 1);
        check_val("mem_addr", mem_addr, maddr_exp);
        check_val("done_overlap", if_done && d_done, 0);
        for (int r = 0; r < 2; r++) begin
            e  = gnt[r] && (done_cyc[r] == cyc);
            dn = (r == 0) ? if_done : d_done;
            rd = (r == 0) ? if_rdata : d_rdata;
            check_val((r == 0) ? "if_done" : "d_done", dn, e);
            if (e) begin
                check_val((r == 0) ? "if_rdata" : "d_rdata", rd, exp_data[r]);
                check_val("err", err, exp_err[r]);
                last_rdata[r] = rd;
                last_err[r]   = err;
                lat[r]        = cyc - start_cyc[r];
                done_log.push_back(r);
                gnt[r]     = 1'b0;
                in_done[r] = 1'b1;   // req stays high through the done cycle
            end else if (in_done[r]) begin
                in_done[r] = 1'b0;
                act[r]     = 1'b0;
            end
            if (!act[r]) begin
                if (nxt_cnt[r] > 0) begin
                    nxt_cnt[r]--;
                    act[r] = 1'b1; ra[r] = nxt_addr[r]; rs[r] = nxt_size[r];
                    start_cyc[r] = cyc;
                end else if (rand_en && $urandom_range(0, 2) == 0) begin
                    act[r] = 1'b1;
                    ra[r]  = $urandom;
                    if ($urandom_range(0, 7) == 0) ra[r] = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                    rs[r]  = 2'($urandom_range(0, 3));
                    start_cyc[r] = cyc;
                end
            end
        end
        drive();
        for (int r = 0; r < 2; r++) pend[r] = act[r] && !gnt[r] && !in_done[r];
        if (cyc >= next_grant && (pend[0] || pend[1])) begin
            pick     = (pend[0] && (!pend[1] || !prefer_d)) ? 0 : 1;
            prefer_d = (pick == 0);
            n        = beats_of(pick, rs[pick]);
            bad      = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            bad = misaligned(ra[pick], n);
`endif
            if (bad) begin
                exp_data[pick] = '0; exp_err[pick] = 1'b1; n = 0;
            end else begin
                exp_data[pick] = assemble(ra[pick], n); exp_err[pick] = 1'b0;
            end
            gnt[pick]      = 1'b1;
            done_cyc[pick] = cyc + n + 1;
            next_grant     = cyc + n + 1;
            xfer_base      = ra[pick];
            xfer_t         = cyc;
            xfer_n         = n;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 60 && (act[0] || act[1] || gnt[0] || gnt[1] || nxt_cnt[0] > 0 || nxt_cnt[1] > 0)) begin
            step();
            i++;
        end
        check_val("drain_idle", act[0] || act[1] || gnt[0] || gnt[1], 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_if_done"}, if_done, 0);
        check_val({tag, "_d_done"}, d_done, 0);
        check_val({tag, "_if_rdata"}, if_rdata, 0);
        check_val({tag, "_d_rdata"}, d_rdata, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_mem_addr"}, mem_addr, 0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        model_reset();
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // Fetch word at 0x10
        mem[8'h10] = 8'h13; mem[8'h11] = 8'h57; mem[8'h12] = 8'h9B; mem[8'h13] = 8'hDF;
        issue(0, 32'h10, 2'b10, 1);
        drain();
        check_val("fetch_word", last_rdata[0], 32'hDF9B5713);
        check_val("fetch_lat", lat[0], 5);

        // Half at 0x20, byte at 0x21
        mem[8'h20] = 8'hAA; mem[8'h21] = 8'hBB;
        issue(1, 32'h20, 2'b01, 1);
        drain();
        check_val("half_data", last_rdata[1], 32'h0000BBAA);
        check_val("half_lat", lat[1], 3);
        issue(1, 32'h21, 2'b00, 1);
        drain();
        check_val("byte_data", last_rdata[1], 32'h000000BB);
        check_val("byte_lat", lat[1], 2);

        // Address wrap (an unaligned word, so rejected when checking is on)
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
        issue(1, 32'hFFFF_FFFE, 2'b10, 1);
        drain();
`ifdef MEM_ARB_ALIGN_CHECK_EN
        check_val("wrap_data", last_rdata[1], 32'h0);
        check_val("wrap_err", last_err[1], 1);
`else
        check_val("wrap_data", last_rdata[1], 32'h44332211);
        check_val("wrap_err", last_err[1], 0);
`endif

        // Unaligned word at 0x22
        mem[8'h22] = 8'hC1; mem[8'h23] = 8'hC2; mem[8'h24] = 8'hC3; mem[8'h25] = 8'hC4;
        issue(1, 32'h22, 2'b10, 1);
        drain();
`ifdef MEM_ARB_ALIGN_CHECK_EN
        check_val("unal_data", last_rdata[1], 32'h0);
        check_val("unal_err", last_err[1], 1);
        check_val("unal_lat", lat[1], 1);
`else
        check_val("unal_data", last_rdata[1], 32'hC4C3C2C1);
        check_val("unal_err", last_err[1], 0);
        check_val("unal_lat", lat[1], 5);
`endif

        // Reset during beat 2 of a fetch
        issue(0, 32'h40, 2'b10, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (gnt[0] && cyc == xfer_t + 3) found = 1'b1;
        end
        check_val("reach_beat2", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(6);

        // Contention straight after reset: expect F, D, F, D
        done_log.delete();
        issue(0, 32'h80, 2'b10, 2);
        issue(1, 32'h90, 2'b10, 2);
        drain();
        check_val("contend_count", done_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < done_log.size()) check_val("contend_order", done_log[i], i % 2);
        end

        // Randomized traffic
        rand_en = 1'b1;
        run(3000);
        rand_en = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_byte_arbiter.md
Name: mem_byte_arbiter

Overview:
- Shares one byte-wide, asynchronous-read memory between the instruction-fetch port and the data-load port of the core.
- Sequences multi-byte accesses one byte per cycle and assembles little-endian words.
- Returns each result with a single-cycle done pulse.
- Sits between the core front end/LSU and the byte ROM/RAM array.

Parameters:
- ADDRESS_WIDTH, 32, byte address width of memory and requesters
- DATA_WIDTH, 8, memory data width (one byte per beat)
- WORD_WIDTH, 32, assembled result width (4 x DATA_WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held high until if_done
- if_addr  in  ADDRESS_WIDTH  fetch byte address; always a word access
- if_rdata  out  WORD_WIDTH  fetched instruction, valid while if_done=1
- if_done  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request, held high until d_done
- d_addr  in  ADDRESS_WIDTH  data byte address
- d_size  in  2  00=byte, 01=half, 10/11=word
- d_rdata  out  WORD_WIDTH  zero-extended load data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse to data
- err  out  1  misalignment flag, valid with either done pulse (see Optional Feature)
- mem_addr  out  ADDRESS_WIDTH  byte address to memory
- mem_rdata  in  DATA_WIDTH  combinational read data for mem_addr

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, beat counter=0, pointer favours fetch.
  - All outputs 0: if_done, d_done, if_rdata, d_rdata, err, mem_addr.
  - Reset mid-transfer aborts the transfer; no done pulse follows.
- States: IDLE, XFER.
- IDLE:
  - Arbitrates at each rising edge among requests. A request is ignored in the same cycle as its own done pulse, because the requester drops req then.
  - One requester pending: it is granted.
  - Both pending: round-robin. The pointer favours fetch after reset and after every data grant; it favours data after every fetch grant.
  - On grant: latch base address, beat count N (fetch=4; data: 1/2/4 by d_size) and owner. Go to XFER with beat=0.
- XFER, each cycle:
  - mem_addr = base + beat, modulo 2^ADDRESS_WIDTH. Wrap from all-ones to 0 is legal.
  - mem_rdata is captured into byte lane [beat] of the result register at the rising edge.
  - Lanes >= N are 0.
  - After capturing beat N-1, return to IDLE and raise the owner's done for exactly the next cycle, with rdata driven.
- Outside its done cycle, rdata holds the last value (no requirement); checks apply only during done.
- mem_addr holds its last value in IDLE.
- Latency from req sampled in IDLE to done high: word = 5 cycles, half = 3 cycles, byte = 2 cycles.
- Back-to-back: a pending other requester is granted at the rising edge that ends the done cycle, so there is one idle memory cycle between transfers.
- Address/size changes while a transfer is in flight are ignored (latched at grant).
- Dropping req before done is illegal; behaviour in that case is unspecified.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - At grant, word with addr[1:0]!=0 or half with addr[0]!=0 is rejected. This applies to fetch as well.
  - No XFER beats are issued; the owner's done pulses in the next cycle with rdata=0 and err=1.
  - err=0 on all aligned completions.
  - Round-robin pointer updates as for a normal grant.
- Undefined: no alignment check; unaligned accesses proceed byte by byte; err tied 0.

Test Plan:
- Fetch word: if_req=1, if_addr=0x10, memory bytes 0x10..0x13 = 13,57,9B,DF -> mem_addr steps 0x10,0x11,0x12,0x13; if_done high in cycle 5 with if_rdata=0xDF9B5713.
- Data half/byte: d_size=01 at 0x20 (bytes AA,BB) -> d_rdata=0x0000BBAA after 3 cycles; d_size=00 at 0x21 -> 0x000000BB after 2 cycles.
- Contention: if_req and d_req both high from reset -> fetch served first, then data granted at the edge ending if_done. Repeat -> grants alternate F,D,F,D; no done pulses overlap.
- Wrap: d_size=10, d_addr=0xFFFFFFFE -> mem_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001; bytes assemble in that order.
- Reset mid-op: assert rst_n=0 at beat 2 of a fetch -> all outputs 0 immediately; after release, no if_done without a new request; first tie goes to fetch.
- With MEM_ARB_ALIGN_CHECK_EN: d_size=10, d_addr=0x22 -> no mem_addr change; d_done next cycle with err=1, d_rdata=0. Without the macro, the same access returns bytes 0x22..0x25 with err=0.
